// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transfer in flight, address decode
// for the SPI register and XIP flash windows, optional ACCESS-phase watchdog.
module axi4lite_apb_bridge #(
  parameter logic [31:0] FLASH_BASE     = 32'h3000_0000,
  parameter logic [31:0] FLASH_END      = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE       = 32'h1000_1000,
  parameter logic [31:0] SPI_END        = 32'h1000_1fff,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic [2:0]  pprot,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_e      state_q, state_d;
  logic        ar_full_q, ar_full_d, aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [31:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [2:0]  ar_prot_q, ar_prot_d, aw_prot_q, aw_prot_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        last_wr_q, last_wr_d, cur_wr_q, cur_wr_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [2:0]  pprot_q, pprot_d;
  logic        rvalid_q, rvalid_d, bvalid_q, bvalid_d;
  logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;

  logic        ar_hs, aw_hs, w_hs, rd_avail, wr_avail, pick_wr, rd_done, wr_done;
  logic [31:0] rd_addr, wr_addr, wr_data, sel_addr;
  logic [2:0]  rd_prot, wr_prot;
  logic [3:0]  wr_strb;

  function automatic logic in_window(input logic [31:0] a);
    return ((a >= FLASH_BASE) && (a <= FLASH_END)) ||
           ((a >= SPI_BASE) && (a <= SPI_END));
  endfunction

  assign arready = !ar_full_q;
  assign awready = !aw_full_q;
  assign wready  = !w_full_q;

  // IDLE may launch straight from an incoming handshake, so each candidate
  // looks through to the bus when its buffer is still empty.
  assign ar_hs    = arvalid && !ar_full_q;
  assign aw_hs    = awvalid && !aw_full_q;
  assign w_hs     = wvalid && !w_full_q;
  assign rd_avail = ar_full_q || ar_hs;
  assign wr_avail = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign rd_addr  = ar_full_q ? ar_addr_q : araddr;
  assign rd_prot  = ar_full_q ? ar_prot_q : arprot;
  assign wr_addr  = aw_full_q ? aw_addr_q : awaddr;
  assign wr_prot  = aw_full_q ? aw_prot_q : awprot;
  assign wr_data  = w_full_q ? w_data_q : wdata;
  assign wr_strb  = w_full_q ? w_strb_q : wstrb;
  assign pick_wr  = wr_avail && (!rd_avail || !last_wr_q);
  assign sel_addr = pick_wr ? wr_addr : rd_addr;
  assign rd_done  = (state_q == S_RESP) && !cur_wr_q && rready;
  assign wr_done  = (state_q == S_RESP) && cur_wr_q && bready;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    cur_wr_d  = cur_wr_q;
    wcnt_d    = wcnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_avail || wr_avail) begin
          cur_wr_d = pick_wr;
          if (in_window(sel_addr)) begin
            state_d   = S_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = sel_addr;
            pprot_d   = pick_wr ? wr_prot : rd_prot;
            pwrite_d  = pick_wr;
            pwdata_d  = pick_wr ? wr_data : 32'h0;
            pstrb_d   = pick_wr ? wr_strb : 4'b0000;
          end else begin
            state_d = S_RESP;
            if (pick_wr) begin
              bvalid_d = 1'b1;
              bresp_d  = 2'b11;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = 2'b11;
              rdata_d  = 32'h0;
            end
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        wcnt_d    = 32'h0;
      end
      S_ACCESS: begin
        if (pready || ((TIMEOUT_CYCLES != 0) && (wcnt_q == TO_LAST))) begin
          state_d   = S_RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (cur_wr_q) begin
            bvalid_d = 1'b1;
            bresp_d  = (!pready || pslverr) ? 2'b10 : 2'b00;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = (!pready || pslverr) ? 2'b10 : 2'b00;
            rdata_d  = pready ? prdata : 32'h0;
          end
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      S_RESP: begin
        if (rd_done) begin
          rvalid_d  = 1'b0;
          last_wr_d = 1'b0;
          state_d   = S_IDLE;
        end else if (wr_done) begin
          bvalid_d  = 1'b0;
          last_wr_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A completing response and a new handshake in the same cycle leave the
  // buffer full with the new entry.
  always_comb begin
    ar_full_d = rd_done ? 1'b0 : ar_full_q;
    aw_full_d = wr_done ? 1'b0 : aw_full_q;
    w_full_d  = wr_done ? 1'b0 : w_full_q;
    if (ar_hs) ar_full_d = 1'b1;
    if (aw_hs) aw_full_d = 1'b1;
    if (w_hs)  w_full_d  = 1'b1;
    ar_addr_d = ar_hs ? araddr : ar_addr_q;
    ar_prot_d = ar_hs ? arprot : ar_prot_q;
    aw_addr_d = aw_hs ? awaddr : aw_addr_q;
    aw_prot_d = aw_hs ? awprot : aw_prot_q;
    w_data_d  = w_hs ? wdata : w_data_q;
    w_strb_d  = w_hs ? wstrb : w_strb_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ar_full_q <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      last_wr_q <= 1'b1;
      cur_wr_q  <= 1'b0;
      wcnt_q    <= 32'h0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pstrb_q   <= 4'b0000;
      pprot_q   <= 3'b000;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ar_full_q <= ar_full_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      last_wr_q <= last_wr_d;
      cur_wr_q  <= cur_wr_d;
      wcnt_q    <= wcnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clock) begin
    ar_addr_q <= ar_addr_d;
    ar_prot_q <= ar_prot_d;
    aw_addr_q <= aw_addr_d;
    aw_prot_q <= aw_prot_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;
  assign pprot   = pprot_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Bench for axi4lite_apb_bridge: a bridge without watchdog and one with a
// 16-cycle watchdog, driven from shared stimulus against a transaction model.
module tb_axi4lite_apb_bridge;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        awvalid, wvalid, bready, arvalid, rready, pready, pslverr;
  logic [31:0] awaddr, wdata, araddr, prdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  logic        awready0, wready0, bvalid0, arready0, rvalid0, psel0, penable0, pwrite0;
  logic        awready1, wready1, bvalid1, arready1, rvalid1, psel1, penable1, pwrite1;
  logic [1:0]  bresp0, rresp0, bresp1, rresp1;
  logic [31:0] rdata0, paddr0, pwdata0, rdata1, paddr1, pwdata1;
  logic [2:0]  pprot0, pprot1;
  logic [3:0]  pstrb0, pstrb1;

  axi4lite_apb_bridge #(.TIMEOUT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready0), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready0), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid0), .bready(bready), .bresp(bresp0),
    .arvalid(arvalid), .arready(arready0), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid0), .rready(rready), .rdata(rdata0), .rresp(rresp0),
    .paddr(paddr0), .psel(psel0), .penable(penable0), .pprot(pprot0),
    .pwrite(pwrite0), .pwdata(pwdata0), .pstrb(pstrb0),
    .pready(pready), .prdata(prdata), .pslverr(pslverr));

  axi4lite_apb_bridge #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready1), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready1), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid1), .bready(bready), .bresp(bresp1),
    .arvalid(arvalid), .arready(arready1), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid1), .rready(rready), .rdata(rdata1), .rresp(rresp1),
    .paddr(paddr1), .psel(psel1), .penable(penable1), .pprot(pprot1),
    .pwrite(pwrite1), .pwdata(pwdata1), .pstrb(pstrb1),
    .pready(pready), .prdata(prdata), .pslverr(pslverr));

  // Observed bridge: 0 = no watchdog, 1 = 16-cycle watchdog
  logic use_wd = 1'b0;
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_psel, m_penable, m_pwrite;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata, m_paddr, m_pwdata;
  logic [2:0]  m_pprot;
  logic [3:0]  m_pstrb;
  assign m_awready = use_wd ? awready1 : awready0;
  assign m_wready  = use_wd ? wready1  : wready0;
  assign m_bvalid  = use_wd ? bvalid1  : bvalid0;
  assign m_arready = use_wd ? arready1 : arready0;
  assign m_rvalid  = use_wd ? rvalid1  : rvalid0;
  assign m_psel    = use_wd ? psel1    : psel0;
  assign m_penable = use_wd ? penable1 : penable0;
  assign m_pwrite  = use_wd ? pwrite1  : pwrite0;
  assign m_bresp   = use_wd ? bresp1   : bresp0;
  assign m_rresp   = use_wd ? rresp1   : rresp0;
  assign m_rdata   = use_wd ? rdata1   : rdata0;
  assign m_paddr   = use_wd ? paddr1   : paddr0;
  assign m_pwdata  = use_wd ? pwdata1  : pwdata0;
  assign m_pprot   = use_wd ? pprot1   : pprot0;
  assign m_pstrb   = use_wd ? pstrb1   : pstrb0;

  // APB slave: pready after sl_waits wait states (negative = never)
  int          sl_waits = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_rd_err = 1'b0, sl_wr_err = 1'b0;
  int          acc_cnt = 0;
  int          apb_count = 0;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_strb;
  logic [2:0]  rec_prot;
  logic        rec_write;

  always @(negedge clock) begin
    if (m_psel && m_penable) begin
      pready  <= (sl_waits >= 0) && (acc_cnt == sl_waits);
      acc_cnt <= acc_cnt + 1;
    end else begin
      pready  <= 1'b0;
      acc_cnt <= 0;
    end
    prdata  <= sl_rdata;
    pslverr <= m_pwrite ? sl_wr_err : sl_rd_err;
  end

  always @(posedge clock) begin
    if (m_psel && !m_penable) begin
      apb_count <= apb_count + 1;
      rec_addr  <= m_paddr;
      rec_wdata <= m_pwdata;
      rec_strb  <= m_pstrb;
      rec_prot  <= m_pprot;
      rec_write <= m_pwrite;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h3000_0000 && a <= 32'h3fff_ffff) ||
           (a >= 32'h1000_1000 && a <= 32'h1000_1fff);
  endfunction

  // Transaction-level expectation: response code, read data, latency from
  // the (last) address/data handshake to the response, and whether APB is used.
  function automatic void model(input logic [31:0] addr, input int waits, input bit err,
                                input logic [31:0] data, input int to,
                                output logic [1:0] resp, output logic [31:0] rd,
                                output int lat, output bit apb);
    if (!in_win(addr)) begin
      resp = 2'b11; rd = 32'h0; lat = 2; apb = 1'b0;
    end else if (to != 0 && (waits < 0 || waits >= to)) begin
      resp = 2'b10; rd = 32'h0; lat = 2 + to; apb = 1'b1;
    end else begin
      resp = err ? 2'b10 : 2'b00; rd = data; lat = 3 + waits; apb = 1'b1;
    end
  endfunction

  task automatic wait_resp(input bit wr, output int lat, output logic [1:0] s1, output logic [1:0] s2);
    lat = 0; s1 = 2'b00; s2 = 2'b00;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) s1 = {m_psel, m_penable};
      if (lat == 2) s2 = {m_psel, m_penable};
    end while (!(wr ? m_bvalid : m_rvalid) && lat < 400);
  endtask

  task automatic finish_resp(input bit wr, input string tag);
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(posedge clock);
    #1 bready = 1'b0; rready = 1'b0;
    @(negedge clock);
    check({tag, "_valid_drop"}, wr ? m_bvalid : m_rvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int waits,
                         input bit err, input logic [31:0] data, input int to);
    logic [1:0] er; logic [31:0] ed; int el, lat, c0; bit ea; logic [1:0] s1, s2;
    model(addr, waits, err, data, to, er, ed, el, ea);
    sl_waits = waits; sl_rd_err = err; sl_rdata = data;
    @(negedge clock);
    c0 = apb_count;
    check("rd_arready", m_arready, 1'b1);
    arvalid = 1'b1; araddr = addr; arprot = prot;
    @(posedge clock);
    #1 arvalid = 1'b0;
    wait_resp(1'b0, lat, s1, s2);
    check("rd_rvalid", m_rvalid, 1'b1);
    check("rd_rresp", m_rresp, er);
    check("rd_rdata", m_rdata, ed);
    check("rd_apb_used", apb_count - c0, ea ? 1 : 0);
    if (ea) begin
      check("rd_latency", lat, el);
      check("rd_setup_phase", s1, 2'b10);
      check("rd_access_phase", s2, 2'b11);
      check("rd_psel_after", {m_psel, m_penable}, 2'b00);
      check("rd_paddr", rec_addr, addr);
      check("rd_pctl", {rec_write, rec_strb, rec_prot}, {1'b0, 4'b0000, prot});
      check("rd_pwdata", rec_wdata, 32'h0);
    end else begin
      check("rd_decerr_latency_le2", lat <= el, 1'b1);
    end
    finish_resp(1'b0, "rd");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                          input logic [3:0] strb, input int wdel, input int waits, input bit err,
                          input int to);
    logic [1:0] er; logic [31:0] ed; int el, lat, c0; bit ea, pre; logic [1:0] s1, s2;
    model(addr, waits, err, 32'h0, to, er, ed, el, ea);
    sl_waits = waits; sl_wr_err = err;
    @(negedge clock);
    c0 = apb_count;
    awvalid = 1'b1; awaddr = addr; awprot = prot;
    if (wdel == 0) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
    @(posedge clock);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    if (wdel > 0) begin
      pre = 1'b0;
      for (int i = 1; i < wdel; i++) begin
        @(negedge clock);
        pre |= m_psel;
        if (i == 1) check("wr_awready_held", {m_awready, m_wready}, 2'b01);
      end
      @(negedge clock);
      pre |= m_psel;
      check("wr_no_setup_before_w", {pre, 31'(apb_count - c0)}, 32'h0);
      wvalid = 1'b1; wdata = data; wstrb = strb;
      @(posedge clock);
      #1 wvalid = 1'b0;
    end
    wait_resp(1'b1, lat, s1, s2);
    check("wr_bvalid", m_bvalid, 1'b1);
    check("wr_bresp", m_bresp, er);
    check("wr_apb_used", apb_count - c0, ea ? 1 : 0);
    if (ea) begin
      check("wr_latency", lat, el);
      check("wr_phases", {s1, s2}, 4'b1011);
      check("wr_paddr", rec_addr, addr);
      check("wr_pctl", {rec_write, rec_strb, rec_prot}, {1'b1, strb, prot});
      check("wr_pwdata", rec_wdata, data);
    end else begin
      check("wr_decerr_latency_le2", lat <= el, 1'b1);
    end
    finish_resp(1'b1, "wr");
  endtask

  // Read and write presented in the same cycle; the first response is held
  // for `hold` cycles before being accepted.
  task automatic arb_pair(input bit exp_wr_first, input int hold, input bit werr);
    logic [31:0] ra, wa, wd, rd; int n, c0; bit pre;
    ra = 32'h1000_1000 + {20'h0, 12'($urandom_range(0, 32'hfff))};
    wa = 32'h1000_1000 + {20'h0, 12'($urandom_range(0, 32'hfff))};
    wd = $urandom; rd = $urandom;
    sl_waits = 0; sl_rdata = rd; sl_rd_err = 1'b0; sl_wr_err = werr;
    @(negedge clock);
    c0 = apb_count;
    arvalid = 1'b1; araddr = ra; arprot = 3'b000;
    awvalid = 1'b1; awaddr = wa; awprot = 3'b001;
    wvalid = 1'b1; wdata = wd; wstrb = 4'hf;
    @(posedge clock);
    #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!(m_rvalid || m_bvalid) && n < 50);
    check("arb_first_dir", {m_bvalid, m_rvalid, rec_write}, {exp_wr_first, !exp_wr_first, exp_wr_first});
    pre = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      pre |= m_psel;
    end
    check("arb_hold_no_second", {pre, 31'(apb_count - c0)}, 32'h1);
    check("arb_first_valid_held", exp_wr_first ? m_bvalid : m_rvalid, 1'b1);
    finish_resp(exp_wr_first, "arb_first");
    n = 0;
    while (!(exp_wr_first ? m_rvalid : m_bvalid) && n < 50) begin @(negedge clock); n++; end
    check("arb_second_dir", {apb_count - c0, 31'(rec_write)}, {32'h2, 31'(!exp_wr_first)} );
    if (exp_wr_first) begin
      check("arb_rresp", {m_rresp, m_rdata}, {2'b00, rd});
    end else begin
      check("arb_bresp", m_bresp, werr ? 2'b10 : 2'b00);
    end
    check("arb_addr", rec_addr, exp_wr_first ? ra : wa);
    finish_resp(!exp_wr_first, "arb_second");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    int kind;
    bit pre;
    reset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; araddr = 0; awprot = 0; arprot = 0; wstrb = 0;
    @(negedge clock);
    check("rst_psel_penable", {m_psel, m_penable, m_pwrite}, 3'b000);
    check("rst_paddr", m_paddr, 32'h0);
    check("rst_pwdata", m_pwdata, 32'h0);
    check("rst_pstrb_pprot", {m_pstrb, m_pprot}, 7'h0);
    check("rst_valids", {m_rvalid, m_bvalid}, 2'b00);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_resps", {m_rresp, m_bresp}, 4'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_readies", {m_arready, m_awready, m_wready}, 3'b111);

    do_read(32'h1000_1010, 3'b000, 0, 1'b0, 32'h0000_0140, 0);
    do_write(32'h1000_1014, 3'b010, 32'h1, 4'b0011, 3, 0, 1'b0, 0);
    do_read(32'h3000_0004, 3'b100, 200, 1'b0, 32'hdead_beef, 0);
    do_read(32'h2000_0000, 3'b000, 0, 1'b0, 32'h1234_5678, 0);
    do_write(32'h0000_0000, 3'b000, 32'h55, 4'hf, 0, 0, 1'b0, 0);

    arb_pair(1'b0, 5, 1'b1);
    do_read(32'h3000_0100, 3'b000, 1, 1'b0, $urandom, 0);
    arb_pair(1'b1, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 2);
      d = $urandom;
      if (kind == 0) a = 32'h1000_1000 + {20'h0, 12'($urandom_range(0, 32'hfff))};
      else if (kind == 1) a = 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
      else a = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 4), 1'($urandom_range(0, 1)), d, 0);
      else
        do_write(a, 3'($urandom_range(0, 7)), d, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    // Reset while the bridge sits in ACCESS
    sl_waits = -1;
    @(negedge clock);
    arvalid = 1'b1; araddr = 32'h1000_1100; arprot = 3'b000;
    @(posedge clock);
    #1 arvalid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_in_access", {m_psel, m_penable}, 2'b11);
    #2 reset = 1'b1;
    #1 check("mid_rst_psel_drop", {m_psel, m_penable}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    pre = 1'b0;
    repeat (5) begin @(negedge clock); pre |= m_rvalid | m_psel; end
    check("mid_rst_no_resp", pre, 1'b0);
    check("mid_rst_arready", m_arready, 1'b1);

    use_wd = 1'b1;
    do_read(32'h1000_1200, 3'b000, -1, 1'b0, 32'hcafe_f00d, 16);
    do_read(32'h3000_0200, 3'b000, 15, 1'b0, 32'h0bad_cafe, 16);
    do_write(32'h3000_0300, 3'b000, 32'h1357_9bdf, 4'hf, 0, -1, 1'b0, 16);
    do_read(32'h1000_1204, 3'b000, 2, 1'b1, 32'h2468_ace0, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4lite_apb_bridge.md
Name: axi4lite_apb_bridge

Overview:
Upstream neighbour of the SPI APB wrapper. Converts single AXI4-Lite read/write transactions from the CPU-side crossbar into APB3/APB4 master transfers, with one transfer outstanding at a time. Decodes the SPI-master register window and the XIP flash window; any other address returns DECERR without an APB access. An optional watchdog aborts APB accesses that never complete, such as a stalled XIP flash read.

Parameters:
FLASH_BASE, 32'h3000_0000, first byte of XIP flash window
FLASH_END, 32'h3fff_ffff, last byte of XIP flash window
SPI_BASE, 32'h1000_1000, first byte of SPI-master register window
SPI_END, 32'h1000_1fff, last byte of SPI-master register window
TIMEOUT_CYCLES, 0, maximum ACCESS-phase cycles before abort; 0 disables the watchdog

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
awvalid/awready  in/out  1/1  AXI write-address handshake
awaddr  in  32  write address
awprot  in  3  write protection
wvalid/wready  in/out  1/1  AXI write-data handshake
wdata  in  32  write data
wstrb  in  4  write byte strobes
bvalid/bready  out/in  1/1  write-response handshake
bresp  out  2  write response
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  32  read address
arprot  in  3  read protection
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  32  read data
rresp  out  2  read response
paddr  out  32  APB address
psel  out  1  APB select
penable  out  1  APB enable
pprot  out  3  APB protection
pwrite  out  1  APB write
pwdata  out  32  APB write data
pstrb  out  4  APB byte strobes
pready  in  1  APB ready
prdata  in  32  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Holding buffers: AR, AW and W each have a one-entry buffer with a valid flag.
  - arready = !ar_full; awready = !aw_full; wready = !w_full. No combinational path from any valid input to any ready output.
  - All buffers are empty at reset, so every ready output is 1 once reset is released.
  - A buffer fills on its valid&&ready handshake. It empties only when its response handshake completes (R for AR; B for both AW and W).
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. FSM returns to IDLE.
- Reset mid-operation aborts the transfer immediately; psel and penable drop in the same cycle reset asserts. No response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Candidates are a read (ar_full) or a write (aw_full && w_full). A write waits until both AW and W buffers are full.
  - If both candidates are ready, the one not served last wins (round-robin). After reset, read has priority.
  - Address decode of the selected address:
    - In the FLASH window or the SPI window → SETUP.
    - Anything else → RESP with resp=2'b11 (DECERR), rdata=0. No APB activity.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - paddr, pprot and pwrite come from the winning buffer.
  - Write: pwdata=wdata, pstrb=wstrb.
  - Read: pwdata=0, pstrb=4'b0000.
  - Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1. All address/control/data outputs stay stable.
  - Wait-state counter starts at 0 and increments each cycle pready=0.
  - On pready=1: capture prdata (reads only) and pslverr; resp = pslverr ? 2'b10 : 2'b00. Next state is RESP.
  - Watchdog (only when TIMEOUT_CYCLES != 0): if the counter reaches TIMEOUT_CYCLES with pready=0, abort. Next state is RESP with resp=2'b10 and rdata=0.
- RESP:
  - psel=0 and penable=0 in the first RESP cycle. This releases the downstream XIP DONE hold.
  - Read: rvalid=1 until rready. Write: bvalid=1 until bready.
  - On the handshake: empty the buffer(s), record the direction served, go to IDLE. rvalid/bvalid drop the following cycle.
- Latency for a zero-wait-state read: AR handshake in cycle N, SETUP at N+1, ACCESS at N+2 (pready sampled), rvalid=1 at N+3.
- Simultaneous events:
  - A new AR/AW/W may be accepted in any state while its buffer is empty. Acceptance does not disturb the transfer in flight.
  - A buffer emptying and refilling in the same cycle is allowed: the handshake wins, and the buffer stays full with the new entry.
- Only one APB transfer is ever in flight. psel never deasserts inside SETUP or ACCESS unless the watchdog aborts or reset asserts.

Test Plan:
- Read SPI window: araddr=0x1000_1010, slave pready after 0 waits, prdata=0x0000_0140 → psel at N+1, penable at N+2, rvalid at N+3, rdata=0x0000_0140, rresp=00.
- Write with strobes: awaddr=0x1000_1014, wdata=0x1, wstrb=4'b0011, W arrives 3 cycles after AW → SETUP only after W accepted; pstrb=0011, pwrite=1, bresp=00.
- XIP long wait: araddr=0x3000_0004, pready after 200 cycles, prdata=0xdead_beef, TIMEOUT_CYCLES=0 → rdata=0xdead_beef, rresp=00; psel/penable low the cycle after pready.
- Decode error: araddr=0x2000_0000 → psel never asserts, rresp=11 within 2 cycles; write to 0x0 → bresp=11.
- Arbitration/backpressure: AR and AW+W valid together, rready held low 5 cycles → read served first; write starts only after R handshake; pslverr=1 on write → bresp=10.
- Watchdog and reset: TIMEOUT_CYCLES=16, pready stuck 0 → rresp=10, rdata=0 after 16 wait cycles; separately, reset asserted in ACCESS → psel=0 immediately, no rvalid, arready=1 after release.
